// File: rtl/microcode_pkg.sv
// microcode_pkg: shared widths, microword layout, FSM states and the default microprogram
package microcode_pkg;
  localparam int DEF_STATE_W = 3;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_WAIT_W = 4;
  localparam int DEF_DEPTH = 2 ** DEF_STATE_W;
  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_STATE_W-1:0] addr_t;
    logic [DEF_STATE_W-1:0] addr_f;
    logic [1:0] csel;
    logic cinv;
    logic [DEF_WAIT_W-1:0] wait_cnt;
    logic halt;
  } microword_t;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DWELL, ST_DONE} seq_state_t;
  function automatic microword_t mw(input logic [DEF_CTRL_W-1:0] c, input logic [DEF_STATE_W-1:0] t,
                                    input logic [DEF_STATE_W-1:0] f, input logic [1:0] s, input logic i,
                                    input logic [DEF_WAIT_W-1:0] w, input logic h);
    mw = '{ctrl: c, addr_t: t, addr_f: f, csel: s, cinv: i, wait_cnt: w, halt: h};
  endfunction
  // Straight-line program 0->1->2->3 halting at 3; spare words loop on themselves.
  localparam microword_t [DEF_DEPTH-1:0] DEFAULT_ROM = {
    mw(8'h00, 3'd7, 3'd7, 2'd0, 1'b0, 4'd0, 1'b0),
    mw(8'h00, 3'd6, 3'd6, 2'd0, 1'b0, 4'd0, 1'b0),
    mw(8'h00, 3'd5, 3'd5, 2'd0, 1'b0, 4'd0, 1'b0),
    mw(8'h00, 3'd4, 3'd4, 2'd0, 1'b0, 4'd0, 1'b0),
    mw(8'hA3, 3'd0, 3'd0, 2'd0, 1'b0, 4'd0, 1'b1),
    mw(8'hA2, 3'd3, 3'd3, 2'd0, 1'b0, 4'd0, 1'b0),
    mw(8'hA1, 3'd2, 3'd2, 2'd0, 1'b0, 4'd0, 1'b0),
    mw(8'hA0, 3'd1, 3'd1, 2'd0, 1'b0, 4'd0, 1'b0)
  };
endpackage

// File: rtl/microcode_sequencer_if.sv
// microcode_sequencer_if: sequencer <-> next-state register / controller signal bundle
interface microcode_sequencer_if import microcode_pkg::*; #(
  parameter int STATE_W = DEF_STATE_W,
  parameter int CTRL_W = DEF_CTRL_W
);
  logic start;
  logic [3:0] cond;
  logic [STATE_W-1:0] cur_state;
  logic [STATE_W-1:0] next_state;
  logic load;
  logic state_clr;
  logic [CTRL_W-1:0] ctrl;
  logic busy;
  logic done;
  modport slave (input start, cond, cur_state, output next_state, load, state_clr, ctrl, busy, done);
  modport master (output start, cond, cur_state, input next_state, load, state_clr, ctrl, busy, done);
endinterface

// File: rtl/cond_sync.sv
// cond_sync: two-flop per-bit synchroniser for asynchronous condition flags
module cond_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q, s2_q;
  // Two back-to-back stages give metastability settling time before use.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: two-address microcode next-address stage with run/halt and dwell; COND_SYNC_EN adds cond synchroniser
module microcode_sequencer import microcode_pkg::*; #(
  parameter int STATE_W = DEF_STATE_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int WAIT_W = DEF_WAIT_W,
  parameter logic [2**STATE_W-1:0][CTRL_W+2*STATE_W+WAIT_W+3:0] ROM = DEFAULT_ROM
) (
  input logic clk,
  input logic reset_n,
  microcode_sequencer_if.slave bus
);
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [STATE_W-1:0] addr_t;
    logic [STATE_W-1:0] addr_f;
    logic [1:0] csel;
    logic cinv;
    logic [WAIT_W-1:0] wait_cnt;
    logic halt;
  } word_t;
  word_t w;
  logic [3:0] cond_s;
  logic c;
  seq_state_t state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  assign w = ROM[bus.cur_state];
`ifdef COND_SYNC_EN
  cond_sync #(.W(4)) u_cond_sync (.clk(clk), .reset_n(reset_n), .d(bus.cond), .q(cond_s));
`else
  assign cond_s = bus.cond;
`endif
  assign c = cond_s[w.csel] ^ w.cinv;
  assign bus.next_state = c ? w.addr_t : w.addr_f;
  // FSM state and dwell counter; reset lands in IDLE so the register is held clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // Next state and outputs; load only fires in the last cycle a word is occupied.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bus.load = 1'b0;
    bus.state_clr = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.ctrl = '0;
    case (state_q)
      ST_IDLE: begin
        bus.state_clr = 1'b1;
        state_d = bus.start ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: begin
        bus.busy = 1'b1;
        bus.ctrl = w.ctrl;
        if (w.wait_cnt != '0) begin
          cnt_d = w.wait_cnt;
          state_d = ST_DWELL;
        end else if (w.halt) begin
          state_d = ST_DONE;
        end else begin
          bus.load = 1'b1;
        end
      end
      ST_DWELL: begin
        bus.busy = 1'b1;
        bus.ctrl = w.ctrl;
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(1)) begin
          bus.load = !w.halt;
          state_d = w.halt ? ST_DONE : ST_EXEC;
        end
      end
      default: begin
        bus.done = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: directed checks of reset, linear run, branching, dwell, cond latency and mid-dwell reset
module tb_microcode_sequencer;
  import microcode_pkg::*;
`ifdef COND_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  localparam microword_t [7:0] ROM_B = {
    mw(8'hB7, 3'd0, 3'd0, 2'd0, 1'b0, 4'd0, 1'b1),
    mw(8'hB6, 3'd5, 3'd4, 2'd2, 1'b1, 4'd0, 1'b0),
    mw(8'hB5, 3'd2, 3'd2, 2'd0, 1'b0, 4'd0, 1'b0),
    mw(8'hB4, 3'd2, 3'd2, 2'd0, 1'b0, 4'd0, 1'b0),
    mw(8'hB3, 3'd0, 3'd0, 2'd0, 1'b0, 4'd0, 1'b1),
    mw(8'hB2, 3'd3, 3'd7, 2'd0, 1'b0, 4'd3, 1'b0),
    mw(8'hB1, 3'd5, 3'd4, 2'd2, 1'b0, 4'd0, 1'b0),
    mw(8'hB0, 3'd1, 3'd1, 2'd0, 1'b0, 4'd0, 1'b0)
  };
  typedef struct {
    logic [2:0] cur;
    logic [3:0] cond;
    logic [2:0] nxt;
  } bvec_t;
  typedef struct {
    int cur;
    int load;
    int nxt;
    int ctrl;
    int busy;
    int done;
  } dvec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic man = 1'b0;
  logic [2:0] man_cur = '0;
  logic [2:0] reg_a = '0;
  logic [2:0] reg_b = '0;
  int total = 0;
  int bad = 0;
  bvec_t bv[8];
  dvec_t dv[9];
  microcode_sequencer_if if_a ();
  microcode_sequencer_if if_b ();
  microcode_sequencer dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  microcode_sequencer #(.ROM(ROM_B)) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  assign if_a.cur_state = reg_a;
  assign if_b.cur_state = man ? man_cur : reg_b;
  always #5 clk = ~clk;
  // Model of the external next-state register: sync clear, else load.
  always @(posedge clk) begin
    if (if_a.state_clr) reg_a <= '0;
    else if (if_a.load) reg_a <= if_a.next_state;
    if (if_b.state_clr) reg_b <= '0;
    else if (if_b.load) reg_b <= if_b.next_state;
  end
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", n, act, exp);
    end
  endtask
  task automatic idle_chk(input string n);
    chk({n, "_busy"}, int'(if_b.busy), 0);
    chk({n, "_done"}, int'(if_b.done), 0);
    chk({n, "_load"}, int'(if_b.load), 0);
    chk({n, "_ctrl"}, int'(if_b.ctrl), 0);
    chk({n, "_clr"}, int'(if_b.state_clr), 1);
  endtask
  initial begin
    bv = '{'{3'd1, 4'b0100, 3'd5}, '{3'd1, 4'b0000, 3'd4}, '{3'd1, 4'b1011, 3'd4}, '{3'd6, 4'b0100, 3'd4},
           '{3'd6, 4'b0000, 3'd5}, '{3'd2, 4'b0001, 3'd3}, '{3'd2, 4'b0000, 3'd7}, '{3'd0, 4'b1111, 3'd1}};
    dv = '{'{0, 1, 1, 'hB0, 1, 0}, '{1, 1, 4, 'hB1, 1, 0}, '{4, 1, 2, 'hB4, 1, 0},
           '{2, 0, 7, 'hB2, 1, 0}, '{2, 0, SYNC ? 7 : 3, 'hB2, 1, 0}, '{2, 0, SYNC ? 7 : 3, 'hB2, 1, 0},
           '{2, 1, 3, 'hB2, 1, 0}, '{3, 0, 0, 'hB3, 1, 0}, '{3, 0, 0, 0, 0, 1}};
    if_a.start = 1'b0;
    if_a.cond = '0;
    if_b.start = 1'b0;
    if_b.cond = '0;
    #2;
    idle_chk("rst");
    chk("rst_a_clr", int'(if_a.state_clr), 1);
    chk("rst_a_busy", int'(if_a.busy), 0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) if_a.start = 1'b1;
    @(negedge clk) if_a.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("lin_cur", int'(reg_a), i);
      chk("lin_ctrl", int'(if_a.ctrl), 'hA0 + i);
      chk("lin_busy", int'(if_a.busy), 1);
      chk("lin_clr", int'(if_a.state_clr), 0);
      chk("lin_load", int'(if_a.load), i < 3 ? 1 : 0);
      chk("lin_done", int'(if_a.done), 0);
      if (i < 3) chk("lin_next", int'(if_a.next_state), i + 1);
    end
    @(negedge clk);
    chk("lin_done_pulse", int'(if_a.done), 1);
    chk("lin_done_busy", int'(if_a.busy), 0);
    chk("lin_done_load", int'(if_a.load), 0);
    chk("lin_done_ctrl", int'(if_a.ctrl), 0);
    if_a.start = 1'b1;
    @(negedge clk) if_a.start = 1'b0;
    chk("lin_after_done", int'(if_a.done), 0);
    chk("lin_after_clr", int'(if_a.state_clr), 1);
    @(negedge clk);
    chk("lin_start_in_done_ignored_busy", int'(if_a.busy), 0);
    chk("lin_start_in_done_ignored_clr", int'(if_a.state_clr), 1);
    man = 1'b1;
    foreach (bv[i]) begin
      man_cur = bv[i].cur;
      if_b.cond = bv[i].cond;
      repeat (3) @(negedge clk);
      chk($sformatf("br%0d_next", i), int'(if_b.next_state), int'(bv[i].nxt));
    end
    idle_chk("br_idle");
    man = 1'b0;
    if_b.cond = '0;
    repeat (3) @(negedge clk);
    if_b.start = 1'b1;
    @(negedge clk) if_b.start = 1'b0;
    foreach (dv[i]) begin
      if (i > 0) @(negedge clk);
      if (i == 4) begin
        if_b.cond = 4'b0001;
        #1;
      end
      chk($sformatf("dw%0d_cur", i), int'(reg_b), dv[i].cur);
      chk($sformatf("dw%0d_load", i), int'(if_b.load), dv[i].load);
      chk($sformatf("dw%0d_next", i), int'(if_b.next_state), dv[i].nxt);
      chk($sformatf("dw%0d_ctrl", i), int'(if_b.ctrl), dv[i].ctrl);
      chk($sformatf("dw%0d_busy", i), int'(if_b.busy), dv[i].busy);
      chk($sformatf("dw%0d_done", i), int'(if_b.done), dv[i].done);
    end
    @(negedge clk) if_b.cond = '0;
    idle_chk("dw_end");
    repeat (3) @(negedge clk);
    if_b.start = 1'b1;
    @(negedge clk) if_b.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rd_pre_cur", int'(reg_b), 2);
    chk("rd_pre_busy", int'(if_b.busy), 1);
    reset_n = 1'b0;
    #1;
    idle_chk("rd_now");
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_chk($sformatf("rd_post%0d", i));
      @(negedge clk);
    end
    if_b.start = 1'b1;
    @(negedge clk) if_b.start = 1'b0;
    chk("rs_cur", int'(reg_b), 0);
    chk("rs_load", int'(if_b.load), 1);
    chk("rs_next", int'(if_b.next_state), 1);
    chk("rs_ctrl", int'(if_b.ctrl), 'hB0);
    @(negedge clk);
    chk("rs_cur1", int'(reg_b), 1);
    chk("rs_ctrl1", int'(if_b.ctrl), 'hB1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

- Upstream next-address stage of the two-address microcode control unit.
- Holds the microprogram ROM and reads the word addressed by the current state (the 3-bit next-state register's output).
- Picks one of the word's two next addresses from a selected condition input, and drives the register's data, load and clear pins.
- Adds run/halt control, per-state dwell counting and optional condition synchronisation.

## Interface
Parameters:
- STATE_W, 3, width of state address (ROM depth 2**STATE_W)
- CTRL_W, 8, width of control-word field
- WAIT_W, 4, width of dwell field
- ROM, DEFAULT_ROM (package), packed array of 2**STATE_W microwords

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin program from state 0 (honoured in IDLE only)
- cond  in  4  external condition flags
- cur_state  in  STATE_W  current state from next-state register
- next_state  out  STATE_W  selected next address (register inData)
- load  out  1  register load strobe
- state_clr  out  1  register synchronous clear
- ctrl  out  CTRL_W  control field of current word
- busy  out  1  program running
- done  out  1  one-cycle pulse on halt

## Operation
- Microword fields: ctrl[CTRL_W], addr_t[STATE_W], addr_f[STATE_W], csel[2], cinv, wait[WAIT_W], halt.
- Condition: c = cond_s[csel] ^ cinv. next_state = c ? addr_t : addr_f, driven combinationally from cur_state at all times.
- FSM states: IDLE, EXEC, DWELL, DONE.
- IDLE:
  - state_clr=1, so the register is held at 0.
  - busy=0, load=0, ctrl=0.
  - start=1 -> EXEC.
- EXEC: busy=1, ctrl=ROM[cur_state].ctrl.
  - wait==0 and halt=0: load=1, stay EXEC.
  - wait==0 and halt=1: load=0 -> DONE.
  - wait>0: load=0, cnt<=wait -> DWELL.
- DWELL: busy=1, ctrl as EXEC, cnt decrements each cycle.
  - On the cycle where cnt==1: halt=0 gives load=1 -> EXEC; halt=1 -> DONE.
- DONE: done=1, busy=0, load=0, ctrl=0 -> IDLE.
- start outside IDLE is ignored, including in DONE.
- Self-loop words (addr_t==addr_f==cur_state) are legal and run until reset.
- A state with wait=W is occupied W+1 cycles; load is high only in the last of them.

## Timing
- All outputs are 0 during and after reset, except state_clr=1 (FSM in IDLE). cnt and synchroniser flops also reset to 0.
- Start: start sampled high at edge k; EXEC from k; state_clr drops after k. State 0 executes in the cycle after k.
- Register update: load high in cycle n; cur_state changes at the edge ending n. Word for the new state is valid in n+1.
- Halt: done is high exactly 1 cycle, the cycle after the halting word's last cycle. busy is low in that cycle.
- Reset mid-operation: reset_n low forces IDLE asynchronously and clears cnt. No load or done is emitted.
- Combinational path: cur_state -> ROM -> mux -> next_state/load, within one cycle.

## Configuration
- COND_SYNC_EN defined:
  - cond passes through a 2-flop synchroniser per bit (reset 0); cond_s lags cond by 2 edges.
- COND_SYNC_EN undefined:
  - cond_s = cond, with zero latency.
  - Callers must supply cond synchronous to clk.

## Structure
- Package microcode_pkg holds:
  - widths STATE_W/CTRL_W/WAIT_W defaults
  - microword struct typedef
  - FSM state enum
  - DEFAULT_ROM constant
- One sub-module, cond_sync: a 2-flop per-bit synchroniser, instantiated only under COND_SYNC_EN.

## Test plan
- Reset: reset_n=0 mid-clock -> busy=0, done=0, load=0, ctrl=0, state_clr=1 immediately.
- Linear program:
  - ROM 0->1->2->3, wait=0, halt at 3.
  - Pulse start -> load high 3 consecutive cycles with next_state 1,2,3.
  - done pulses once, one cycle after state 3; then state_clr=1.
- Branch:
  - State 1: csel=2, addr_t=5, addr_f=4, cond=4'b0100 -> next_state=5.
  - Repeat with cinv=1 -> next_state=4.
- Dwell: state 2 with wait=3 -> cur_state=2 for 4 cycles, load high only in the 4th, ctrl constant throughout.
- Sync (COND_SYNC_EN): toggle cond[0] during a dwell -> next_state reflects it exactly 2 edges later. Without the macro, it reflects it in the same cycle.
- Reset mid-dwell: assert reset_n=0 at cnt=2 -> IDLE, no load/done. Restart with start -> execution resumes at state 0.
